// File: rtl/convert_results.sv
// Walks numElements IEEE-754 singles out of the float_register RAM, converts each
// to a saturating signed 32-bit integer and writes it to the result RAM at the same index.
module convert_results (
  input  logic        clk,
  input  logic        program_reset_n,
  input  logic        start_process,
  output logic        end_process,
  input  logic [4:0]  numElements,
  output logic [4:0]  float_register_addr,
  input  logic [31:0] float_register_out,
  output logic [4:0]  result_addr,
  output logic [31:0] result_data,
  output logic        result_wren,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE,
    SET_ADDR,
    READ_WAIT,
    CONVERT,
    WRITE,
    DONE
  } state_t;

  state_t     state, next_state;
  logic [4:0] index, next_index;
  logic [4:0] count, next_count;

  function automatic logic signed [31:0] saturate(input logic s);
    return s ? 32'sh80000000 : 32'sh7FFFFFFF;
  endfunction

  // Truncating float->int; NaN and |x|<1 collapse to 0, so -0 never appears.
  function automatic logic signed [31:0] float_to_int(input logic [31:0] f);
    logic        s;
    logic [7:0]  e;
    logic [22:0] m;
    logic [31:0] mag;
    s   = f[31];
    e   = f[30:23];
    m   = f[22:0];
    mag = {8'd0, 1'b1, m};
    if (e == 8'hFF && m != 23'd0) return '0;
    if (e >= 8'd158)              return saturate(s);
    if (e < 8'd127)               return '0;
    if (e <= 8'd150) mag = mag >> (8'd150 - e);
    else             mag = mag << (e - 8'd150);
    return s ? -$signed(mag) : $signed(mag);
  endfunction

  always_ff @(posedge clk) begin
    if (!program_reset_n) begin
      state <= IDLE;
      index <= '0;
      count <= '0;
    end else begin
      state <= next_state;
      index <= next_index;
      count <= next_count;
    end
  end

  always_comb begin
    next_state  = state;
    next_index  = index;
    next_count  = count;
    result_wren = 1'b0;
    end_process = 1'b0;
    busy        = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start_process) begin
          next_count = numElements;
          next_index = '0;
          next_state = (numElements == 5'd0) ? DONE : SET_ADDR;
        end
      end
      SET_ADDR:  next_state = READ_WAIT;
      READ_WAIT: next_state = CONVERT;
      CONVERT:   next_state = WRITE;
      WRITE: begin
        result_wren = 1'b1;
        if (index == count - 5'd1) begin
          next_state = DONE;
        end else begin
          next_index = index + 5'd1;
          next_state = SET_ADDR;
        end
      end
      DONE: begin
        busy        = 1'b0;
        end_process = 1'b1;
        if (!start_process) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Address is loaded on entry to SET_ADDR and held through READ_WAIT/CONVERT;
  // the converted word is registered at the end of CONVERT so it lines up with result_wren.
  always_ff @(posedge clk) begin
    if (!program_reset_n) begin
      float_register_addr <= '0;
      result_addr         <= '0;
      result_data         <= '0;
    end else begin
      if (next_state == SET_ADDR) float_register_addr <= next_index;
      if (state == CONVERT) begin
        result_data <= $unsigned(float_to_int(float_register_out));
        result_addr <= index;
      end
    end
  end

endmodule
